// File: rtl/br_local_arbiter.sv
// Round-robin arbiter sharing one router LOCAL injection port among N_REQ on-tile sources.
// Optional strict priority for requester 0 when BR_ARB_PRIO0_EN is defined.
package br_local_arbiter_pkg;
    localparam int BR_DATA_W = 16;
    typedef logic [BR_DATA_W-1:0] br_data_t;
endpackage

module br_local_arbiter
    import br_local_arbiter_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int GRANT_W = $clog2(N_REQ)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  br_data_t [N_REQ-1:0]   src_flit_i,
    input  logic [N_REQ-1:0]       src_req_i,
    output logic [N_REQ-1:0]       src_ack_o,
    output br_data_t               rt_flit_o,
    output logic                   rt_req_o,
    input  logic                   rt_ack_i,
    input  logic                   rt_busy_i,
    output logic [GRANT_W-1:0]     grant_o,
    output logic                   active_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ACK  = 2'd2,
        REL  = 2'd3
    } state_t;

    localparam int IDX_W = GRANT_W + 1;
    localparam logic [GRANT_W-1:0] LAST_IDX = GRANT_W'(N_REQ - 1);

    state_t             state_q, state_d;
    logic               rt_req_q, rt_req_d;
    logic [N_REQ-1:0]   src_ack_q, src_ack_d;
    logic [GRANT_W-1:0] grant_q, grant_d;
    logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
    br_data_t           flit_q, flit_d;

    logic [GRANT_W-1:0] cand_idx [N_REQ];
    logic [GRANT_W-1:0] rr_winner;
    logic [GRANT_W-1:0] win_idx;
    logic [GRANT_W-1:0] grant_inc;
    logic               any_req;

    // Candidate order starting at rr_ptr; the wrap uses an explicit compare so
    // non-power-of-two N_REQ rotates correctly.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_cand
            logic [IDX_W-1:0] sum;
            assign sum = {1'b0, rr_ptr_q} + IDX_W'(gi);
            assign cand_idx[gi] = (sum >= IDX_W'(N_REQ)) ? GRANT_W'(sum - IDX_W'(N_REQ))
                                                         : GRANT_W'(sum);
        end
    endgenerate

    always_comb begin
        rr_winner = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (src_req_i[cand_idx[i]]) begin
                rr_winner = cand_idx[i];
            end
        end
    end

    assign any_req   = |src_req_i;
    assign grant_inc = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;

`ifdef BR_ARB_PRIO0_EN
    assign win_idx = src_req_i[0] ? '0 : rr_winner;
`else
    assign win_idx = rr_winner;
`endif

    always_comb begin
        state_d   = state_q;
        rt_req_d  = rt_req_q;
        src_ack_d = src_ack_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        flit_d    = flit_q;
        unique case (state_q)
            IDLE: begin
                if (any_req && !rt_busy_i) begin
                    grant_d  = win_idx;
                    flit_d   = src_flit_i[win_idx];
                    rt_req_d = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                // The granted source's req is not watched here: the latched flit
                // is delivered even if the source withdrew early.
                if (rt_ack_i) begin
                    src_ack_d          = '0;
                    src_ack_d[grant_q] = 1'b1;
                    state_d            = ACK;
                end
            end
            ACK: begin
                if (!src_req_i[grant_q]) begin
                    rt_req_d  = 1'b0;
                    src_ack_d = '0;
                    state_d   = REL;
                end
            end
            REL: begin
                if (!rt_ack_i) begin
`ifdef BR_ARB_PRIO0_EN
                    if (grant_q != '0) begin
                        rr_ptr_d = grant_inc;
                    end
`else
                    rr_ptr_d = grant_inc;
`endif
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            rt_req_q  <= 1'b0;
            src_ack_q <= '0;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            flit_q    <= '0;
        end else begin
            state_q   <= state_d;
            rt_req_q  <= rt_req_d;
            src_ack_q <= src_ack_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            flit_q    <= flit_d;
        end
    end

    assign src_ack_o = src_ack_q;
    assign rt_flit_o = flit_q;
    assign rt_req_o  = rt_req_q;
    assign grant_o   = grant_q;
    assign active_o  = (state_q != IDLE);

endmodule

// File: doc/br_local_arbiter.md
Name: br_local_arbiter

Overview:
- Shares one router LOCAL injection port among N_REQ on-tile sources, e.g. kernel, monitor and application injectors.
- Each source uses the same 4-phase req/ack handshake as the router local port.
- The arbiter grants round-robin, forwards the granted source's flit, and relays the router ack back to that source.
- Sits between the PE-side injectors and the router's flit_i/req_i/ack_o LOCAL signals, with new grants gated by the router's local busy flag.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- GRANT_W, $clog2(N_REQ), width of the grant index.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- src_flit_i  in  N_REQ x br_data_t  per-requester flit; must be stable while its req is high
- src_req_i  in  N_REQ  per-requester request
- src_ack_o  out  N_REQ  per-requester ack; at most one bit high
- rt_flit_o  out  br_data_t  flit to router LOCAL input
- rt_req_o  out  1  request to router LOCAL input
- rt_ack_i  in  1  ack from router LOCAL input
- rt_busy_i  in  1  router local_busy; high means no new local broadcast may start
- grant_o  out  GRANT_W  index of current or last granted requester
- active_o  out  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE, rt_req_o=0, src_ack_o=0, rt_flit_o='0, grant_o=0, active_o=0, rr_ptr=0.
- FSM states: IDLE, REQ, ACK, REL.
- IDLE:
  - If any src_req_i is high and rt_busy_i=0: select the winner by round-robin starting at rr_ptr (lowest index at or after rr_ptr, wrapping at N_REQ-1 -> 0).
  - Latch the winner into grant_o, register its flit into rt_flit_o, go to REQ.
  - If rt_busy_i=1: no grant; stay in IDLE, requests held.
- REQ:
  - rt_req_o=1 (first asserted the cycle after the IDLE decision; latency is one cycle from src_req to rt_req).
  - rt_flit_o holds the latched flit and is not re-sampled.
  - On rt_ack_i=1: src_ack_o[grant]=1 next cycle, go to ACK.
- ACK:
  - src_ack_o[grant]=1, rt_req_o=1.
  - When src_req_i[grant]=0: drop rt_req_o and src_ack_o[grant] next cycle, go to REL.
- REL:
  - Wait for rt_ack_i=0, then set rr_ptr=(grant+1) mod N_REQ and go to IDLE.
  - Minimum back-to-back service: 5 cycles per flit when router acks in 1 cycle.
- Non-granted requesters:
  - Their src_ack_o stays 0; their requests are held and are not lost.
  - A req raised and dropped without ack is ignored.
- Simultaneous events:
  - New requests arriving in REQ/ACK/REL wait for IDLE.
  - rt_busy_i rising after a grant does not abort the transaction; the handshake completes.
- A granted requester dropping req before ack (protocol violation): ignored. The arbiter continues the REQ with the latched flit and completes when ack arrives.
- rr_ptr arithmetic: wraps at N_REQ; non-power-of-two N_REQ supported via explicit compare, not bit truncation.
- Reset mid-operation: all outputs return to reset values immediately (async); the in-flight router handshake is abandoned.

Optional Feature:
- BR_ARB_PRIO0_EN:
  - Defined: requester 0 has strict priority. In IDLE, if src_req_i[0]=1 it wins regardless of rr_ptr, and rr_ptr is not updated after serving 0. The remaining requesters rotate as normal.
  - Undefined: pure round-robin over all N_REQ.

Test Plan:
- Single requester 2 sends flit 0xA5 with router ack after 1 cycle -> rt_req_o rises 1 cycle after src_req_i[2]; rt_flit_o=0xA5; src_ack_o=0b0100; grant_o=2; back to IDLE with rr_ptr=3.
- All 4 requesters held high, 8 transactions -> grant order 0,1,2,3,0,1,2,3 (macro off); with BR_ARB_PRIO0_EN and req0 always high -> grant 0 every transaction.
- rt_busy_i=1 for 10 cycles while src_req_i=0b0011 -> rt_req_o stays 0 and active_o=0; busy drops -> grant 0 next cycle.
- Requester 1 changes src_flit_i from 0x11 to 0x22 after grant -> rt_flit_o stays 0x11 until REL.
- Router delays ack_i deassert 6 cycles in REL -> no new grant until rt_ack_i=0; requester 3 pending is then served.
- rst_ni pulsed low during ACK -> same-cycle rt_req_o=0, src_ack_o=0, state IDLE, rr_ptr=0; after release a pending req0 is granted first.
